stage_e_mdu: RTL and testbench

- Execute stage of the P6 five-stage MIPS pipeline. Holds the D/E pipeline register and consumes decode-stage operands, immediate and control.
- Applies M/W forwarding, computes the ALU result, and hosts the iterative multiply/divide unit (HI/LO) with a busy handshake to the hazard unit.
- Produces the E-stage result, store data, write address and PC+8 for the E/M register and for decode-stage forwarding.

---
 rtl/stage_e_mdu.sv | 247 ++++++++++++++++++++++++
 tb/tb_stage_e_mdu.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_e_mdu.sv
// Execute stage of the five-stage pipeline: D/E register, E-stage operand
// forwarding, ALU, and a multi-cycle multiply/divide unit owning HI/LO.
module stage_e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_e,
    input  logic        stall_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] rs_val_d,
    input  logic [31:0] rt_val_d,
    input  logic [31:0] imm32_d,
    input  logic [4:0]  shamt_d,
    input  logic [4:0]  a3_d,
    input  logic [3:0]  alu_op_d,
    input  logic        alu_src_d,
    input  logic [2:0]  md_op_d,
    input  logic [1:0]  wsel_d,
    input  logic [1:0]  mf_a_sel,
    input  logic [1:0]  mf_b_sel,
    input  logic [31:0] rfwd_m,
    input  logic [31:0] rfwd_w,
    output logic [31:0] res_e,
    output logic [31:0] wdata_e,
    output logic [4:0]  a3_e,
    output logic [31:0] pc_e,
    output logic [31:0] pc8_e,
    output logic        md_start,
    output logic        md_busy
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [1:0] WS_HI  = 2'b01;
    localparam logic [1:0] WS_LO  = 2'b10;
    localparam logic [1:0] WS_PC8 = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  a3;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic [2:0]  md_op;
        logic [1:0]  wsel;
    } de_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    // ------------------------------------------------------------------
    // D/E pipeline register
    // ------------------------------------------------------------------
    de_t de_q, de_d;

    always_comb begin
        de_d         = '0;
        de_d.pc      = pc_d;
        if (!(flush_e || stall_d)) begin
            de_d.rs      = rs_val_d;
            de_d.rt      = rt_val_d;
            de_d.imm     = imm32_d;
            de_d.shamt   = shamt_d;
            de_d.a3      = a3_d;
            de_d.alu_op  = alu_op_d;
            de_d.alu_src = alu_src_d;
            de_d.md_op   = md_op_d;
            de_d.wsel    = wsel_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) de_q <= '0;
        else        de_q <= de_d;
    end

    // ------------------------------------------------------------------
    // Forwarding and ALU
    // ------------------------------------------------------------------
    logic [31:0] op_a, b_rt, op_b, alu_res;

    always_comb begin
        case (mf_a_sel)
            2'b01:   op_a = rfwd_m;
            2'b10:   op_a = rfwd_w;
            default: op_a = de_q.rs;
        endcase
        case (mf_b_sel)
            2'b01:   b_rt = rfwd_m;
            2'b10:   b_rt = rfwd_w;
            default: b_rt = de_q.rt;
        endcase
    end

    assign op_b = de_q.alu_src ? de_q.imm : b_rt;

    // Shifts always take the rt path, even when the immediate is selected.
    always_comb begin
        alu_res = '0;
        case (de_q.alu_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a | op_b;
            4'd3:    alu_res = op_a & op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = ~(op_a | op_b);
            4'd6:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd7:    alu_res = {31'd0, op_a < op_b};
            4'd8:    alu_res = {op_b[15:0], 16'd0};
            4'd9:    alu_res = b_rt << de_q.shamt;
            4'd10:   alu_res = b_rt >> de_q.shamt;
            4'd11:   alu_res = $unsigned($signed(b_rt) >>> de_q.shamt);
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply / divide unit
    // ------------------------------------------------------------------
    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mop_q, mop_d;
    logic [31:0]      ma_q, ma_d, mb_q, mb_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;

    assign md_start = (de_q.md_op == MD_MULT) || (de_q.md_op == MD_MULTU) ||
                      (de_q.md_op == MD_DIV)  || (de_q.md_op == MD_DIVU);
    assign md_busy  = (state_q == S_BUSY);

    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{ma_q[31]}}, ma_q} * {{32{mb_q[31]}}, mb_q};
    assign prod_u = {32'd0, ma_q} * {32'd0, mb_q};

    // Signed division runs on magnitudes so MIN_INT / -1 wraps to MIN_INT
    // with a zero remainder instead of hitting an overflow case.
    logic        neg_a, neg_b;
    logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, quot, rem;

    assign neg_a    = (mop_q == MD_DIV) & ma_q[31];
    assign neg_b    = (mop_q == MD_DIV) & mb_q[31];
    assign dvd      = neg_a ? -ma_q : ma_q;
    assign dvs      = neg_b ? -mb_q : mb_q;
    assign dvs_safe = (dvs == '0) ? 32'd1 : dvs;
    assign q_mag    = dvd / dvs_safe;
    assign r_mag    = dvd % dvs_safe;
    assign quot     = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem      = neg_a ? -r_mag : r_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mop_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mop_q   <= mop_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Anything reaching E while busy is dropped; the hazard unit should have
    // held it in D.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mop_d   = mop_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    state_d = S_BUSY;
                    mop_d   = de_q.md_op;
                    ma_d    = op_a;
                    mb_d    = b_rt;
                    cnt_d   = ((de_q.md_op == MD_MULT) || (de_q.md_op == MD_MULTU))
                              ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end else if (de_q.md_op == MD_MTHI) begin
                    hi_d = op_a;
                end else if (de_q.md_op == MD_MTLO) begin
                    lo_d = op_a;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    case (mop_q)
                        MD_MULT:  {hi_d, lo_d} = prod_s;
                        MD_MULTU: {hi_d, lo_d} = prod_u;
                        MD_DIV, MD_DIVU: begin
                            if (mb_q != '0) begin
                                hi_d = rem;
                                lo_d = quot;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_e    = de_q.pc;
    assign pc8_e   = de_q.pc + 32'd8;
    assign a3_e    = de_q.a3;
    assign wdata_e = b_rt;

    always_comb begin
        case (de_q.wsel)
            WS_HI:   res_e = hi_q;
            WS_LO:   res_e = lo_q;
            WS_PC8:  res_e = pc8_e;
            default: res_e = alu_res;
        endcase
    end

endmodule

// File: tb/tb_stage_e_mdu.sv
// Self-checking bench for stage_e_mdu: ALU vector table, randomized ALU and
// MDU traffic against a behavioural model, plus hand-written MDU sequences.
module tb_stage_e_mdu;

    logic        clk;
    logic        reset;
    logic        flush_e, stall_d;
    logic [31:0] pc_d, rs_val_d, rt_val_d, imm32_d;
    logic [4:0]  shamt_d, a3_d;
    logic [3:0]  alu_op_d;
    logic        alu_src_d;
    logic [2:0]  md_op_d;
    logic [1:0]  wsel_d, mf_a_sel, mf_b_sel;
    logic [31:0] rfwd_m, rfwd_w;
    logic [31:0] res_e, wdata_e, pc_e, pc8_e;
    logic [4:0]  a3_e;
    logic        md_start, md_busy;

    int tests = 0;
    int fails = 0;
    logic [31:0] hi_m, lo_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stage_e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .flush_e(flush_e), .stall_d(stall_d),
        .pc_d(pc_d), .rs_val_d(rs_val_d), .rt_val_d(rt_val_d), .imm32_d(imm32_d),
        .shamt_d(shamt_d), .a3_d(a3_d), .alu_op_d(alu_op_d), .alu_src_d(alu_src_d),
        .md_op_d(md_op_d), .wsel_d(wsel_d), .mf_a_sel(mf_a_sel), .mf_b_sel(mf_b_sel),
        .rfwd_m(rfwd_m), .rfwd_w(rfwd_w), .res_e(res_e), .wdata_e(wdata_e),
        .a3_e(a3_e), .pc_e(pc_e), .pc8_e(pc8_e), .md_start(md_start), .md_busy(md_busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  sh;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_d(input logic [3:0] op, input logic src, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] sh,
                         input logic [4:0] a3, input logic [2:0] md, input logic [1:0] ws,
                         input logic [31:0] pc);
        alu_op_d = op; alu_src_d = src; rs_val_d = rs; rt_val_d = rt; imm32_d = imm;
        shamt_d = sh; a3_d = a3; md_op_d = md; wsel_d = ws; pc_d = pc;
    endtask

    task automatic nop();
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'd0, 32'h0);
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] brt, input logic [31:0] imm,
                                              input logic src, input logic [4:0] sh);
        logic [31:0] b;
        b = src ? imm : brt;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a | b;
            4'd3:  return a & b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return {b[15:0], 16'h0000};
            4'd9:  return brt << sh;
            4'd10: return brt >> sh;
            4'd11: return (brt >> sh) | (brt[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint q, r;
        case (op)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            3'd2: begin
                p = 64'(a) * 64'(b);
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            3'd3: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                lo_m = q[31:0]; hi_m = r[31:0];
            end
            3'd4: if (b != 0) begin
                lo_m = a / b; hi_m = a % b;
            end
            default: ;
        endcase
    endtask

    task automatic mdu_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string nm, output logic [31:0] ghi, output logic [31:0] glo);
        int n;
        int exp_n;
        set_d(4'd0, 1'b0, a, b, 32'd0, 5'd0, 5'd0, op, 2'd0, 32'h1000);
        step();
        chk({nm, "_start"}, {31'd0, md_start}, 32'd1);
        chk({nm, "_busy_at_T"}, {31'd0, md_busy}, 32'd0);
        nop();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (md_busy) n++;
            else break;
        end
        exp_n = (op == 3'd1 || op == 3'd2) ? 5 : 10;
        chk({nm, "_busylen"}, n, exp_n);
        model(op, a, b);
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'b01, 32'h0);
        step();
        ghi = res_e;
        chk({nm, "_hi"}, res_e, hi_m);
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'b10, 32'h0);
        step();
        glo = res_e;
        chk({nm, "_lo"}, res_e, lo_m);
        nop();
    endtask

    initial begin
        logic [31:0] ghi, glo, a, b, ra, rb, ea;
        logic [3:0]  op;
        logic [2:0]  mop;
        logic        src;
        logic [4:0]  sh;
        int          n;

        vt[0]  = '{4'd0,  1'b0, 32'h7FFFFFFF, 32'h1,        32'h0,    5'd0,  32'h80000000, "addu_wrap"};
        vt[1]  = '{4'd1,  1'b0, 32'h0,        32'h1,        32'h0,    5'd0,  32'hFFFFFFFF, "subu_wrap"};
        vt[2]  = '{4'd2,  1'b0, 32'hF0F00000, 32'h00000F0F, 32'h0,    5'd0,  32'hF0F00F0F, "or"};
        vt[3]  = '{4'd3,  1'b0, 32'hFFFF0000, 32'h12345678, 32'h0,    5'd0,  32'h12340000, "and"};
        vt[4]  = '{4'd4,  1'b0, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0,    5'd0,  32'h55555555, "xor"};
        vt[5]  = '{4'd5,  1'b0, 32'h0,        32'h0,        32'h0,    5'd0,  32'hFFFFFFFF, "nor"};
        vt[6]  = '{4'd6,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,    5'd0,  32'h1,        "slt_neg"};
        vt[7]  = '{4'd7,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,    5'd0,  32'h0,        "sltu_big"};
        vt[8]  = '{4'd6,  1'b1, 32'h1,        32'h0,        32'hFFFFFFFF, 5'd0, 32'h0,     "slti_neg"};
        vt[9]  = '{4'd8,  1'b1, 32'h0,        32'h0,        32'h00001234, 5'd0, 32'h12340000, "lui"};
        vt[10] = '{4'd9,  1'b0, 32'h0,        32'h1,        32'h0,    5'd31, 32'h80000000, "sll31"};
        vt[11] = '{4'd10, 1'b0, 32'h0,        32'h80000000, 32'h0,    5'd4,  32'h08000000, "srl"};
        vt[12] = '{4'd11, 1'b0, 32'h0,        32'h80000000, 32'h0,    5'd4,  32'hF8000000, "sra"};
        vt[13] = '{4'd9,  1'b1, 32'h0,        32'h3,        32'hFFFF, 5'd2,  32'h0000000C, "sll_uses_rt"};
        vt[14] = '{4'd12, 1'b0, 32'h5,        32'h5,        32'h0,    5'd0,  32'h0,        "op12_zero"};
        vt[15] = '{4'd15, 1'b1, 32'hFFFFFFFF, 32'h5,        32'hFFFF, 5'd3,  32'h0,        "op15_zero"};

        reset = 1'b0; flush_e = 1'b0; stall_d = 1'b0;
        mf_a_sel = 2'b00; mf_b_sel = 2'b00; rfwd_m = '0; rfwd_w = '0;
        hi_m = '0; lo_m = '0;
        nop();
        #3;
        chk("rst_pc8", pc8_e, 32'd8);
        chk("rst_res", res_e, 32'd0);
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_start", {31'd0, md_start}, 32'd0);
        chk("rst_a3", a3_e, 32'd0);
        reset = 1'b1;

        // ALU vector table
        for (int i = 0; i < 16; i++) begin
            set_d(vt[i].op, vt[i].src, vt[i].rs, vt[i].rt, vt[i].imm, vt[i].sh,
                  5'd3, 3'd0, 2'd0, 32'h400 + 32'(i * 4));
            step();
            chk(vt[i].nm, res_e, vt[i].exp);
        end
        chk("pc8_after_table", pc8_e, 32'h400 + 32'd60 + 32'd8);
        chk("a3_after_table", a3_e, 32'd3);

        // PC+8 select, including wrap
        set_d(4'd0, 1'b0, 32'h1, 32'h1, 32'h0, 5'd0, 5'd31, 3'd0, 2'b11, 32'hFFFFFFFC);
        step();
        chk("pc8_wsel_wrap", res_e, 32'h4);

        // Forwarding
        set_d(4'd2, 1'b1, 32'h1, 32'h77, 32'h3, 5'd0, 5'd2, 3'd0, 2'd0, 32'h0);
        step();
        mf_a_sel = 2'b01; rfwd_m = 32'h10; mf_b_sel = 2'b10; rfwd_w = 32'hDEAD;
        #1;
        chk("fwd_a_m", res_e, 32'h13);
        chk("fwd_b_w", wdata_e, 32'hDEAD);
        mf_a_sel = 2'b11; mf_b_sel = 2'b11;
        #1;
        chk("fwd_a_11", res_e, 32'h3);
        chk("fwd_b_11", wdata_e, 32'h77);
        mf_a_sel = 2'b10; mf_b_sel = 2'b01;
        #1;
        chk("fwd_a_w", res_e, 32'hDEAF);
        chk("fwd_b_m", wdata_e, 32'h10);
        mf_a_sel = 2'b00; mf_b_sel = 2'b00;

        // Flush / stall bubbles
        set_d(4'd0, 1'b0, 32'h5, 32'h6, 32'h0, 5'd0, 5'd9, 3'd0, 2'd0, 32'h300);
        flush_e = 1'b1;
        step();
        chk("flush_a3", a3_e, 32'd0);
        chk("flush_pc", pc_e, 32'h300);
        chk("flush_res", res_e, 32'd0);
        stall_d = 1'b1;
        step();
        chk("flush_stall_a3", a3_e, 32'd0);
        flush_e = 1'b0; stall_d = 1'b0;
        step();
        chk("noflush_a3", a3_e, 32'd9);
        chk("noflush_res", res_e, 32'd11);

        // Randomized ALU with forwarding
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15)); src = 1'($urandom_range(0, 1));
            a = $urandom(); b = $urandom(); sh = 5'($urandom_range(0, 31));
            ea = $urandom();
            set_d(op, src, a, b, ea, sh, 5'd4, 3'd0, 2'd0, 32'h800);
            step();
            mf_a_sel = 2'($urandom_range(0, 3)); mf_b_sel = 2'($urandom_range(0, 3));
            rfwd_m = $urandom(); rfwd_w = $urandom();
            #1;
            ra = (mf_a_sel == 2'b01) ? rfwd_m : (mf_a_sel == 2'b10) ? rfwd_w : a;
            rb = (mf_b_sel == 2'b01) ? rfwd_m : (mf_b_sel == 2'b10) ? rfwd_w : b;
            chk("rand_alu_res", res_e, alu_model(op, ra, rb, ea, src, sh));
            chk("rand_alu_wdata", wdata_e, rb);
            mf_a_sel = 2'b00; mf_b_sel = 2'b00;
        end

        // Directed MDU cases
        mdu_run(3'd1, 32'hFFFFFFFE, 32'd3, "mult_neg", ghi, glo);
        chk("mult_neg_hi_const", ghi, 32'hFFFFFFFF);
        chk("mult_neg_lo_const", glo, 32'hFFFFFFFA);
        mdu_run(3'd3, 32'hFFFFFFF9, 32'd2, "div_neg", ghi, glo);
        chk("div_neg_lo_const", glo, 32'hFFFFFFFD);
        chk("div_neg_hi_const", ghi, 32'hFFFFFFFF);
        mdu_run(3'd4, 32'd1234, 32'd0, "divu_zero", ghi, glo);
        chk("divu_zero_hi_kept", ghi, 32'hFFFFFFFF);
        chk("divu_zero_lo_kept", glo, 32'hFFFFFFFD);
        mdu_run(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf", ghi, glo);
        chk("div_ovf_lo_const", glo, 32'h80000000);
        chk("div_ovf_hi_const", ghi, 32'h0);
        mdu_run(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", ghi, glo);
        chk("multu_max_hi_const", ghi, 32'hFFFFFFFE);

        // Stray mthi / mult while busy must be ignored
        set_d(4'd0, 1'b0, 32'd100, 32'd7, 32'd0, 5'd0, 5'd0, 3'd3, 2'd0, 32'h0);
        step();
        nop();
        step();
        n = md_busy ? 1 : 0;
        set_d(4'd0, 1'b0, 32'h1234, 32'd0, 32'd0, 5'd0, 5'd0, 3'd5, 2'd0, 32'h0);
        step();
        if (md_busy) n++;
        set_d(4'd0, 1'b0, 32'd3, 32'd3, 32'd0, 5'd0, 5'd0, 3'd1, 2'd0, 32'h0);
        step();
        if (md_busy) n++;
        nop();
        for (int k = 0; k < 40; k++) begin
            step();
            if (md_busy) n++;
            else break;
        end
        chk("busy_ignore_len", n, 32'd10);
        model(3'd3, 32'd100, 32'd7);
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'b01, 32'h0);
        step();
        chk("busy_ignore_hi", res_e, 32'd2);
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'b10, 32'h0);
        step();
        chk("busy_ignore_lo", res_e, 32'd14);

        // Stall with mthi in D, then real mthi / mtlo
        set_d(4'd0, 1'b0, 32'hAA, 32'd0, 32'd0, 5'd0, 5'd31, 3'd5, 2'd0, 32'h200);
        stall_d = 1'b1;
        step();
        chk("stall_a3", a3_e, 32'd0);
        chk("stall_pc", pc_e, 32'h200);
        stall_d = 1'b0;
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'b01, 32'h0);
        step();
        chk("stall_hi_kept", res_e, hi_m);
        set_d(4'd0, 1'b0, 32'h55, 32'd0, 32'd0, 5'd0, 5'd0, 3'd5, 2'd0, 32'h0);
        step();
        set_d(4'd0, 1'b0, 32'h66, 32'd0, 32'd0, 5'd0, 5'd0, 3'd6, 2'b01, 32'h0);
        step();
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'b01, 32'h0);
        step();
        chk("mthi", res_e, 32'h55);
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'b10, 32'h0);
        step();
        chk("mtlo", res_e, 32'h66);
        hi_m = 32'h55; lo_m = 32'h66;

        // Randomized MDU traffic
        for (int i = 0; i < 12; i++) begin
            mop = 3'($urandom_range(1, 4));
            a = $urandom();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
            mdu_run(mop, a, b, "rand_mdu", ghi, glo);
        end

        // Reset pulsed on the third busy cycle of divu
        set_d(4'd0, 1'b0, 32'd1000, 32'd3, 32'd0, 5'd0, 5'd0, 3'd4, 2'd0, 32'h0);
        step();
        nop();
        n = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (md_busy) n++;
        end
        chk("abort_busy_before", n, 32'd3);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, md_busy}, 32'd0);
        chk("abort_pc8", pc8_e, 32'd8);
        chk("abort_res", res_e, 32'd0);
        #2;
        reset = 1'b1;
        hi_m = '0; lo_m = '0;
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'b01, 32'h0);
        step();
        chk("abort_hi", res_e, 32'd0);
        set_d(4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 2'b10, 32'h0);
        step();
        chk("abort_lo", res_e, 32'd0);
        set_d(4'd0, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 5'd0, 5'd1, 3'd0, 2'd0, 32'h0);
        step();
        chk("post_rst_addu", res_e, 32'h80000000);
        mdu_run(3'd1, 32'd6, 32'd7, "post_rst_mult", ghi, glo);
        chk("post_rst_mult_lo_const", glo, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
